// File: rtl/program_loader.sv
// Boot-time program loader for the 8-bit RISC machine.
// Streams a payload over valid/ready into SRAM starting at address 0,
// verifies a trailing checksum byte and only then releases the CPU reset.
module program_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  sum_q, sum_d;
  logic               cpu_rst_n_q, cpu_rst_n_d;

  // Running checksum is an 8-bit modular sum; overflow is discarded on purpose.
  function automatic logic [DATA_W-1:0] sum_wrap(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  // A length of zero encodes a full-memory load.
  function automatic logic [CNT_W-1:0] len_to_count(input logic [ADDR_W-1:0] len);
    if (len == '0) return CNT_W'(1) << ADDR_W;
    return {1'b0, len};
  endfunction

  // Control state, address and CPU reset flop; cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  // Byte counter and running sum; always reloaded at load start, so no reset.
  always_ff @(posedge clk) begin
    count_q <= count_d;
    sum_q   <= sum_d;
  end

  // Next-state, datapath updates and handshake/write strobes.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    sum_d     = sum_q;
    in_ready  = 1'b0;
    mem_write = 1'b0;

    case (state_q)
      S_IDLE, S_RUN, S_FAIL: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = len_to_count(load_len);
          addr_d  = '0;
          sum_d   = '0;
        end
      end
      S_LOAD: begin
        in_ready  = 1'b1;
        mem_write = in_valid;
        if (in_valid) begin
          addr_d  = addr_q + ADDR_W'(1);
          count_d = count_q - CNT_W'(1);
          sum_d   = sum_wrap(sum_q, in_data);
          if (count_q == CNT_W'(1)) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // The checksum byte is consumed but never written to memory.
        in_ready = 1'b1;
        if (in_valid) begin
          if (sum_wrap(sum_q, in_data) == '0) state_d = S_RUN;
          else                                state_d = S_FAIL;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // CPU runs exactly while the loader sits in RUN; registered to stay glitch-free.
    cpu_rst_n_d = (state_d == S_RUN);
  end

  assign mem_addr  = addr_q;
  assign mem_data  = in_data;
  assign cpu_rst_n = cpu_rst_n_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign done      = (state_q == S_RUN);
  assign err       = (state_q == S_FAIL);

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader with a behavioural SRAM.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] load_len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_write;
  logic       cpu_rst_n;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [7:0] sram [256] = '{default: 8'hEE};
  int         wr_cnt = 0;

  program_loader #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_len  (load_len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_write (mem_write),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // SRAM model: writes on the rising edge while the strobe is high.
  always @(posedge clk) begin
    if (mem_write) begin
      sram[mem_addr] <= mem_data;
      wr_cnt         <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic start_load(input logic [7:0] len);
    start    = 1'b1;
    load_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'hFF;
  endtask

  initial begin
    logic [7:0] gap_data [7];
    logic       gap_vld  [7];
    int         gap_mw   [7];
    int         gap_ad   [7];
    int         errs;
    int         wr0;

    gap_vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    gap_data = '{8'h11, 8'hFF, 8'hFF, 8'h22, 8'hFF, 8'h33, 8'h9A};
    gap_mw  = '{1, 0, 0, 1, 0, 1, 0};
    gap_ad  = '{0, 1, 1, 1, 2, 2, 3};

    rst = 1'b0; start = 1'b0; load_len = 8'h00; in_data = 8'hFF; in_valid = 1'b0;

    // Reset values, clock not yet risen.
    #2;
    check("rst_in_ready",  32'(in_ready),  0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_mem_addr",  32'(mem_addr),  0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("rst_busy",      32'(busy),      0);
    check("rst_done",      32'(done),      0);
    check("rst_err",       32'(err),       0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 0);
    check("idle_busy",     32'(busy),     0);

    // Basic 3-byte load.
    start_load(8'd3);
    check("basic_in_ready", 32'(in_ready), 1);
    check("basic_busy",     32'(busy),     1);
    in_data = 8'h51; in_valid = 1'b1; #1;
    check("basic_mw0",    32'(mem_write), 1);
    check("basic_addr0",  32'(mem_addr),  0);
    check("basic_mdata0", 32'(mem_data),  'h51);
    @(posedge clk); #1;
    send(8'h60);
    send(8'h00);
    in_data = 8'h4F; in_valid = 1'b1; #1;
    check("basic_ck_mw",   32'(mem_write), 0);
    check("basic_ck_done", 32'(done),      0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("basic_done",      32'(done),      1);
    check("basic_cpu_rst_n", 32'(cpu_rst_n), 1);
    check("basic_busy_off",  32'(busy),      0);
    check("basic_ready_off", 32'(in_ready),  0);
    check("basic_sram0", 32'(sram[0]), 'h51);
    check("basic_sram1", 32'(sram[1]), 'h60);
    check("basic_sram2", 32'(sram[2]), 'h00);
    check("basic_sram3", 32'(sram[3]), 'hEE);

    // Re-load from RUN, then a bad checksum.
    start_load(8'd3);
    check("reload_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("reload_busy",      32'(busy),      1);
    check("reload_done",      32'(done),      0);
    send(8'h51); send(8'h60); send(8'h00); send(8'h50);
    check("bad_err",       32'(err),       1);
    check("bad_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("bad_done",      32'(done),      0);
    start_load(8'd3);
    send(8'h51); send(8'h60); send(8'h00); send(8'h4F);
    check("retry_done",      32'(done),      1);
    check("retry_err",       32'(err),       0);
    check("retry_cpu_rst_n", 32'(cpu_rst_n), 1);

    // Gapped handshake, payload 11 22 33, checksum 9A.
    start_load(8'd3);
    for (int i = 0; i < 7; i++) begin
      in_valid = gap_vld[i];
      in_data  = gap_data[i];
      #1;
      check($sformatf("gap_mw%0d", i),   32'(mem_write), gap_mw[i]);
      check($sformatf("gap_addr%0d", i), 32'(mem_addr),  gap_ad[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("gap_done",  32'(done),    1);
    check("gap_sram0", 32'(sram[0]), 'h11);
    check("gap_sram1", 32'(sram[1]), 'h22);
    check("gap_sram2", 32'(sram[2]), 'h33);
    check("gap_sram3", 32'(sram[3]), 'hEE);

    // Full 256-byte load with load_len=0.
    wr0 = wr_cnt;
    start_load(8'd0);
    for (int i = 0; i < 256; i++) send(8'(i));
    check("full_addr_wrap", 32'(mem_addr), 0);
    check("full_busy",      32'(busy),     1);
    check("full_pre_done",  32'(done),     0);
    send(8'h80);
    check("full_done",   32'(done),      1);
    check("full_cpu",    32'(cpu_rst_n), 1);
    check("full_writes", wr_cnt - wr0,   256);
    errs = 0;
    for (int i = 0; i < 256; i++) if (sram[i] !== 8'(i)) errs++;
    check("full_sram", errs, 0);

    // Reset after 2 of 5 bytes.
    start_load(8'd5);
    send(8'hA1); send(8'hA2);
    #2; rst = 1'b0; #1;
    check("midrst_busy",     32'(busy),      0);
    check("midrst_in_ready", 32'(in_ready),  0);
    check("midrst_addr",     32'(mem_addr),  0);
    check("midrst_cpu",      32'(cpu_rst_n), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle_busy", 32'(busy),   0);
    check("midrst_sram0", 32'(sram[0]), 'hA1);
    check("midrst_sram1", 32'(sram[1]), 'hA2);
    check("midrst_sram2", 32'(sram[2]), 'h02);

    // Start pulses during LOAD are ignored.
    start_load(8'd2);
    start = 1'b1; in_data = 8'h05; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    check("ign_addr1", 32'(mem_addr), 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_addr2", 32'(mem_addr), 1);
    check("ign_busy",  32'(busy),     1);
    send(8'h06);
    in_data = 8'hF5; in_valid = 1'b1; #1;
    check("ign_check_mw", 32'(mem_write), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ign_done", 32'(done), 1);

    // Start in RUN restarts at address 0.
    start_load(8'd1);
    check("rerun_cpu",  32'(cpu_rst_n), 0);
    check("rerun_busy", 32'(busy),      1);
    check("rerun_addr", 32'(mem_addr),  0);
    send(8'h77); send(8'h89);
    check("rerun_done",  32'(done),    1);
    check("rerun_sram0", 32'(sram[0]), 'h77);
    check("rerun_sram1", 32'(sram[1]), 'h06);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader for the 8-bit RISC stored-program machine. It sits directly upstream of the 256 x 8 SRAM, and it holds the processor in reset while it does its work. It accepts a byte stream over a valid/ready handshake and writes the payload into consecutive SRAM locations starting at address 0x00. It then checks a trailing checksum byte and releases the processor only if the checksum passes.

## Interface
- word_size, 8, data width of stream and SRAM word
- addr_size, 8, SRAM address width (256 locations)
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin a load; sampled only in IDLE, RUN, FAIL
- load_len  input  addr_size  payload byte count, latched on accepted start; 0 means 256
- in_data  input  word_size  stream byte
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  loader accepts a byte this cycle
- mem_addr  output  addr_size  SRAM address; drives the SRAM address input
- mem_data  output  word_size  SRAM write data, equal to in_data
- mem_write  output  1  SRAM write strobe; the SRAM writes on the rising edge while this is high
- cpu_rst_n  output  1  processor reset, active-low, registered
- busy  output  1  high in LOAD or CHECK
- done  output  1  high in RUN
- err  output  1  high in FAIL

## Operation
States and transitions:
- **IDLE → LOAD** on start=1. At that edge: latch count = (load_len==0 ? 256 : load_len) in a 9-bit counter, clear addr to 0, clear sum to 0.
- **LOAD → CHECK** on the transfer with count==1.
- **CHECK → RUN** on a transfer with (sum + in_data) mod 256 == 0.
- **CHECK → FAIL** on a transfer with any other value.
- **RUN → LOAD** and **FAIL → LOAD** on start=1, with the same latching as from IDLE.
- **Ignored start:** start has no effect in LOAD or CHECK.

Transfer rule: a transfer is in_valid & in_ready at a rising edge.

Handshake:
- in_ready = 1 in LOAD and CHECK, and 0 otherwise.
- in_valid may toggle freely; the loader never drops or duplicates a byte.

Payload write in LOAD:
- mem_write = in_valid, combinational.
- mem_addr = addr register.
- mem_data = in_data.
- On each transfer: addr increments by 1, modulo 256; count decrements by 1; sum += in_data, modulo 256.

Checksum byte in CHECK:
- mem_write = 0, so the checksum byte is never stored.
- Passing condition: the 8-bit sum of all payload bytes plus the checksum equals 0x00.

Outputs outside LOAD:
- mem_write = 0.
- mem_addr holds the addr register value.

Processor reset:
- cpu_rst_n is a flop.
- It is set to 1 on the edge that enters RUN.
- It is cleared to 0 on the edge that leaves RUN.
- It is 0 in every other state.

Flags:
- busy, done and err decode combinationally from state.

Boundaries:
- load_len=0 writes addresses 0x00..0xFF; addr wraps from 0xFF to 0x00 before CHECK.
- load_len=1 goes from LOAD to CHECK on the first transfer.
- Reset mid-load returns to IDLE immediately. Bytes already written stay in SRAM; there is no rollback.

## Timing
- **Reset values:** state=IDLE, in_ready=0, mem_write=0, mem_addr=0x00, cpu_rst_n=0, busy=0, done=0, err=0.
- **Start latency:** start is accepted at edge E0; in_ready is high from the cycle after E0.
- **Throughput:** one byte per cycle. A gapless load of N payload bytes reaches RUN at edge E0+N+1.
- **Write timing:** the SRAM write for payload byte k (0-based) happens on the same edge as its transfer, at address k mod 256.
- **Release timing:** cpu_rst_n rises at the checksum-transfer edge and is high in the following cycle. done rises in the same cycle.
- **Re-load from RUN:** start in RUN drops cpu_rst_n at that edge, in the same cycle busy rises.

## Test plan
- **Reset values:** assert rst=0 mid-cycle with clk idle -> all outputs take their reset values asynchronously; after release, the block is in IDLE and in_ready=0.
- **Basic 3-byte load:** start with load_len=3, then stream 0x51, 0x60, 0x00, 0x4F gaplessly. Required: SRAM[0..2] = 0x51, 0x60, 0x00; 0x4F is not written; cpu_rst_n=1 and done=1 at E0+4; SRAM[3] is unchanged.
- **Bad checksum:** same payload with checksum 0x50 -> err=1, cpu_rst_n stays 0. A following start with a correct stream reaches RUN.
- **Gapped handshake:** in_valid toggled 1,0,0,1,0,1,1 -> mem_write is high only on valid cycles, addr is stable during gaps, and SRAM contents are identical to the gapless case.
- **Full 256-byte load:** load_len=0 with bytes 0x00..0xFF and checksum 0x80 -> 256 writes; SRAM[i]=i; addr wraps to 0x00; RUN is reached at E0+257.
- **Reset and restart:** assert rst=0 after 2 of 5 bytes -> IDLE, SRAM[0..1] keep their written values. start pulsed during LOAD -> ignored, count is unaffected. start pulsed in RUN -> cpu_rst_n drops at that edge and a new load begins at address 0x00.
